// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter/sequencer in front of a single fixed-latency memory port
// Ports: clk/rst (sync, active-high); if_* fetch requester (read-only);
//   ls_* load/store requester (read/write); mem_* memory port; busy = state != IDLE.
// Build option: MEM_ARB_ROUND_ROBIN_EN alternates grants on conflict; otherwise ls has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic last_ls_q, last_ls_d, src_ls_q, src_ls_d, pick_ls;
  logic if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic mem_we_q, mem_we_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // on conflict, the port that did not win last time goes first
  assign pick_ls = ls_req & (~if_req | ~last_ls_q);
`else
  assign pick_ls = ls_req;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_ls_d = last_ls_q;
    src_ls_d = src_ls_q;
    if_gnt_d = 1'b0;
    ls_gnt_d = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    mem_we_d = 1'b0;
    case (state_q)
      IDLE: if (if_req | ls_req) begin
        state_d = ISSUE;
        src_ls_d = pick_ls;
        last_ls_d = pick_ls;
        if_gnt_d = ~pick_ls;
        ls_gnt_d = pick_ls;
        mem_addr_d = pick_ls ? ls_addr : if_addr;
        mem_din_d = pick_ls ? ls_wdata : '0;
        mem_we_d = pick_ls & ls_we;
      end
      ISSUE: begin
        state_d = mem_we_q ? IDLE : WAIT;
        cnt_d = 3'(RD_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          if_rvalid_d = ~src_ls_q;
          ls_rvalid_d = src_ls_q;
          if_rdata_d = src_ls_q ? if_rdata_q : mem_dout;
          ls_rdata_d = src_ls_q ? mem_dout : ls_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_ls_q <= 1'b0;
      src_ls_q <= 1'b0;
      if_gnt_q <= 1'b0;
      ls_gnt_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      mem_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_ls_q <= last_ls_d;
      src_ls_q <= src_ls_d;
      if_gnt_q <= if_gnt_d;
      ls_gnt_q <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      mem_we_q <= mem_we_d;
    end
  end
  assign if_gnt = if_gnt_q;
  assign ls_gnt = ls_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
  assign mem_we = mem_we_q;
  assign busy = state_q != IDLE;
endmodule
